// File: rtl/modport_fifo_pkg.sv
// modport_fifo shared constants and width helpers.
// Imported by the FIFO top and its storage array.
package modport_fifo_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 16;

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  // Count must represent DEPTH itself, hence depth+1.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/modport_fifo_mem.sv
// modport_fifo storage: DEPTH x WIDTH register array,
// one synchronous write port and one async read port.
module modport_fifo_mem
  import modport_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/modport_fifo.sv
// modport_fifo: single-clock show-ahead FIFO with
// valid/ready push and pop channels gated by sel.
module modport_fifo
  import modport_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel,
  input  logic             w_enable,
  input  logic [WIDTH-1:0] w_data,
  output logic             w_ready,
  output logic             r_enable,
  output logic [WIDTH-1:0] r_data,
  input  logic             r_ready
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] head;
  logic             push;
  logic             pop;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // rst also masks the flags so they drop before the clock.
  assign w_ready  = !rst && (count != CW'(DEPTH));
  assign r_enable = !rst && (count != '0);
  assign r_data   = r_enable ? head : '0;

  assign push = sel && w_enable && w_ready;
  assign pop  = sel && r_enable && r_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop)  rd_ptr <= nxt(rd_ptr);
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

  modport_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (w_data),
    .raddr (rd_ptr),
    .rdata (head)
  );

endmodule

// File: tb/tb_modport_fifo.sv
// Directed bench for modport_fifo.
// Inputs change and outputs are checked on the falling edge.
module tb_modport_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       sel;
  logic       w_enable;
  logic [7:0] w_data;
  logic       w_ready;
  logic       r_enable;
  logic [7:0] r_data;
  logic       r_ready;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  modport_fifo #(
    .WIDTH (8),
    .DEPTH (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sel      (sel),
    .w_enable (w_enable),
    .w_data   (w_data),
    .w_ready  (w_ready),
    .r_enable (r_enable),
    .r_data   (r_data),
    .r_ready  (r_ready)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic flags(
    input string tag,
    input logic  wr,
    input logic  re,
    input int    d
  );
    check({tag, ".w_ready"}, 32'(w_ready), 32'(wr));
    check({tag, ".r_enable"}, 32'(r_enable), 32'(re));
    check({tag, ".r_data"}, 32'(r_data), d);
  endtask

  initial begin
    rst      = 1'b1;
    sel      = 1'b0;
    w_enable = 1'b0;
    w_data   = '0;
    r_ready  = 1'b0;
    #1;
    flags("in_reset", 1'b0, 1'b0, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    flags("after_reset", 1'b1, 1'b0, 0);
    tick();
    flags("idle", 1'b1, 1'b0, 0);

    // single word round trip
    sel      = 1'b1;
    w_enable = 1'b1;
    w_data   = 8'hA5;
    tick();
    w_enable = 1'b0;
    flags("one_word", 1'b1, 1'b1, 'hA5);
    r_ready = 1'b1;
    tick();
    r_ready = 1'b0;
    flags("one_pop", 1'b1, 1'b0, 0);

    // fill to full
    for (int i = 0; i < 16; i++) begin
      w_enable = 1'b1;
      w_data   = 8'(i);
      tick();
    end
    flags("full", 1'b0, 1'b1, 0);
    w_data = 8'hFF;
    tick();
    flags("overflow_drop", 1'b0, 1'b1, 0);

    // full with push+pop: only the pop happens
    w_data  = 8'h77;
    r_ready = 1'b1;
    tick();
    flags("full_pushpop", 1'b1, 1'b1, 1);
    r_ready = 1'b0;
    tick();
    w_enable = 1'b0;
    check("refill.w_ready", 32'(w_ready), 0);

    r_ready = 1'b1;
    for (int i = 1; i < 16; i++) begin
      check($sformatf("drain%0d", i), 32'(r_data), i);
      tick();
    end
    check("drain_tail", 32'(r_data), 'h77);
    tick();
    r_ready = 1'b0;
    flags("drained", 1'b1, 1'b0, 0);

    // sel=0 freezes state
    w_enable = 1'b1;
    w_data   = 8'h11;
    tick();
    w_data = 8'h22;
    tick();
    sel     = 1'b0;
    w_data  = 8'h33;
    r_ready = 1'b1;
    tick();
    tick();
    tick();
    flags("sel_off", 1'b1, 1'b1, 'h11);
    sel      = 1'b1;
    w_enable = 1'b0;
    tick();
    check("sel_on0", 32'(r_data), 'h22);
    tick();
    flags("sel_on1", 1'b1, 1'b0, 0);
    r_ready = 1'b0;

    // steady state at count=5 with wrapping pointers
    for (int i = 0; i < 5; i++) begin
      w_enable = 1'b1;
      w_data   = 8'(8'h40 + i);
      tick();
    end
    r_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      w_data = 8'(8'h45 + k);
      check($sformatf("stream%0d", k), 32'(r_data), 'h40 + k);
      tick();
    end
    w_enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("tail%0d", k), 32'(r_data), 'h68 + k);
      tick();
    end
    r_ready = 1'b0;
    flags("stream_end", 1'b1, 1'b0, 0);

    // async reset mid-stream
    w_enable = 1'b1;
    w_data   = 8'h5C;
    tick();
    tick();
    w_enable = 1'b0;
    check("pre_rst", 32'(r_enable), 1);
    rst = 1'b1;
    #1;
    flags("mid_rst", 1'b0, 1'b0, 0);
    #1;
    rst = 1'b0;
    #1;
    flags("post_rst", 1'b1, 1'b0, 0);
    tick();
    flags("post_rst_idle", 1'b1, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
